// File: rtl/temporizador_multicanal.sv
`default_nettype none
// ============================================================================
//  Module      : temporizador_multicanal
//  Description : Multi-channel presence timer. Each channel watches an
//                active-low infrared input qualified by an enable, counts
//                while presence persists and, on timeout, raises its C output
//                for PULSO_T cycles. Depending on TRAVA it then re-arms at
//                once or latches until the sensor clears. Per-channel state
//                codes and sticky timeout flags are exposed for status readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporizador_multicanal #(
    parameter int N_CANAIS = 4,
    parameter int TIMEOUT  = 30000,
    parameter int PULSO_T  = 1,
    parameter int TRAVA    = 0,
    parameter int CNT_W    = $clog2(TIMEOUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CANAIS-1:0]   enable,
    input  logic [N_CANAIS-1:0]   infravermelho,
    input  logic [N_CANAIS-1:0]   limpa_flag,
    output logic [N_CANAIS-1:0]   C,
    output logic                  qualquer_c,
    output logic [2*N_CANAIS-1:0] estado,
    output logic [N_CANAIS-1:0]   flag_evento
);

    // The same counter times both the presence window and the pulse, so it
    // must be wide enough for whichever of the two is longer.
    localparam int PULSO_W = (PULSO_T > 1) ? $clog2(PULSO_T) : 1;
    localparam int TC_W    = (CNT_W > PULSO_W) ? CNT_W : PULSO_W;

    localparam logic [TC_W-1:0] TC_ZERO      = '0;
    localparam logic [TC_W-1:0] TC_UM        = TC_W'(1);
    localparam logic [TC_W-1:0] TC_FIM_CONTA = TC_W'(TIMEOUT - 1);
    localparam logic [TC_W-1:0] TC_FIM_PULSO = TC_W'(PULSO_T - 1);
    localparam bit              TRAVA_ATIVA  = (TRAVA != 0);

    typedef enum logic [1:0] {
        INICIAL  = 2'd0,
        CONTANDO = 2'd1,
        TEMP     = 2'd2,
        ESPERA   = 2'd3
    } estado_t;

    genvar i;
    generate
        for (i = 0; i < N_CANAIS; i++) begin : g_canal
            estado_t         estado_q;
            estado_t         estado_d;
            logic [TC_W-1:0] tc_q;
            logic [TC_W-1:0] tc_d;
            logic            flag_q;
            logic            presenca;
            logic            entra_temp;

            // A channel only counts while the sensor sees presence and the
            // channel is enabled; both conditions are re-checked every cycle.
            assign presenca   = ~infravermelho[i] & enable[i];
            assign entra_temp = (estado_q == CONTANDO) && (estado_d == TEMP);

            // State and counter register; reset aborts any count or pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    estado_q <= INICIAL;
                    tc_q     <= TC_ZERO;
                end else begin
                    estado_q <= estado_d;
                    tc_q     <= tc_d;
                end
            end

            // Next-state and counter logic for one channel.
            always_comb begin
                estado_d = estado_q;
                tc_d     = tc_q;
                case (estado_q)
                    INICIAL: begin
                        tc_d = TC_ZERO;
                        if (presenca) begin
                            estado_d = CONTANDO;
                        end
                    end
                    CONTANDO: begin
                        // Losing presence wins over reaching the timeout.
                        if (!presenca) begin
                            estado_d = INICIAL;
                            tc_d     = TC_ZERO;
                        end else if (tc_q == TC_FIM_CONTA) begin
                            estado_d = TEMP;
                            tc_d     = TC_ZERO;
                        end else begin
                            tc_d = tc_q + TC_UM;
                        end
                    end
                    TEMP: begin
                        // Inputs are ignored for the whole pulse.
                        if (tc_q == TC_FIM_PULSO) begin
                            estado_d = TRAVA_ATIVA ? ESPERA : INICIAL;
                            tc_d     = TC_ZERO;
                        end else begin
                            tc_d = tc_q + TC_UM;
                        end
                    end
                    ESPERA: begin
                        // Only a cleared sensor releases the latch.
                        tc_d = TC_ZERO;
                        if (infravermelho[i]) begin
                            estado_d = INICIAL;
                        end
                    end
                    default: begin
                        estado_d = INICIAL;
                        tc_d     = TC_ZERO;
                    end
                endcase
            end

            // Sticky timeout flag; a new timeout beats a simultaneous clear.
            always_ff @(posedge clk) begin
                if (rst) begin
                    flag_q <= 1'b0;
                end else if (entra_temp) begin
                    flag_q <= 1'b1;
                end else if (limpa_flag[i]) begin
                    flag_q <= 1'b0;
                end
            end

            assign C[i]             = (estado_q == TEMP);
            assign estado[2*i +: 2] = estado_q;
            assign flag_evento[i]   = flag_q;
        end
    endgenerate

    assign qualquer_c = |C;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_multicanal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temporizador_multicanal
//  Description : Self-checking bench for temporizador_multicanal. Two
//                instances (re-arm and latch variants) share the same
//                stimulus and are compared every cycle against a behavioural
//                model, with extra directed checks at the key instants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temporizador_multicanal;

    localparam int N  = 2;
    localparam int TO = 20;
    localparam int PT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] enable;
    logic [N-1:0] infravermelho;
    logic [N-1:0] limpa_flag;

    logic [N-1:0]   c_a, c_b;
    logic           q_a, q_b;
    logic [2*N-1:0] est_a, est_b;
    logic [N-1:0]   flg_a, flg_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of each channel: cycles of qualified presence counted so far
    // (-1 when not counting), remaining pulse cycles, latch and sticky flag.
    int m_cnt   [2][N];
    int m_pulso [2][N];
    bit m_trava [2][N];
    bit m_flag  [2][N];

    temporizador_multicanal #(
        .N_CANAIS(N), .TIMEOUT(TO), .PULSO_T(PT), .TRAVA(0)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .infravermelho(infravermelho),
        .limpa_flag(limpa_flag), .C(c_a), .qualquer_c(q_a), .estado(est_a),
        .flag_evento(flg_a)
    );

    temporizador_multicanal #(
        .N_CANAIS(N), .TIMEOUT(TO), .PULSO_T(PT), .TRAVA(1)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .infravermelho(infravermelho),
        .limpa_flag(limpa_flag), .C(c_b), .qualquer_c(q_b), .estado(est_b),
        .flag_evento(flg_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                bit set;
                set = 1'b0;
                if (rst) begin
                    m_cnt[d][c] = -1; m_pulso[d][c] = 0;
                    m_trava[d][c] = 1'b0; m_flag[d][c] = 1'b0;
                end else begin
                    if (m_pulso[d][c] > 0) begin
                        m_pulso[d][c]--;
                        if (m_pulso[d][c] == 0 && d == 1) m_trava[d][c] = 1'b1;
                    end else if (m_trava[d][c]) begin
                        if (infravermelho[c]) m_trava[d][c] = 1'b0;
                    end else if (m_cnt[d][c] < 0) begin
                        if (!infravermelho[c] && enable[c]) m_cnt[d][c] = 0;
                    end else if (infravermelho[c] || !enable[c]) begin
                        m_cnt[d][c] = -1;
                    end else if (m_cnt[d][c] + 1 == TO) begin
                        m_cnt[d][c] = -1; m_pulso[d][c] = PT; set = 1'b1;
                    end else begin
                        m_cnt[d][c]++;
                    end
                    if (set) m_flag[d][c] = 1'b1;
                    else if (limpa_flag[c]) m_flag[d][c] = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [1:0] m_estado(int d, int c);
        if (m_pulso[d][c] > 0) return 2'd2;
        if (m_trava[d][c])     return 2'd3;
        if (m_cnt[d][c] >= 0)  return 2'd1;
        return 2'd0;
    endfunction

    task automatic compara_modelo();
        logic [2*N-1:0] e_est [2];
        logic [N-1:0]   e_c   [2];
        logic [N-1:0]   e_f   [2];
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                e_est[d][2*c +: 2] = m_estado(d, c);
                e_c[d][c]          = (m_pulso[d][c] > 0);
                e_f[d][c]          = m_flag[d][c];
            end
        end
        chk("a.estado", 32'(est_a), 32'(e_est[0]));
        chk("a.C",      32'(c_a),   32'(e_c[0]));
        chk("a.qc",     32'(q_a),   32'(|e_c[0]));
        chk("a.flag",   32'(flg_a), 32'(e_f[0]));
        chk("b.estado", 32'(est_b), 32'(e_est[1]));
        chk("b.C",      32'(c_b),   32'(e_c[1]));
        chk("b.qc",     32'(q_b),   32'(|e_c[1]));
        chk("b.flag",   32'(flg_b), 32'(e_f[1]));
    endtask

    // One clock edge: advance the model with the inputs the DUT samples,
    // then compare slightly after the edge.
    task automatic ciclo();
        @(posedge clk);
        model_step();
        #1;
        compara_modelo();
    endtask

    task automatic ciclos(input int n);
        for (int k = 0; k < n; k++) ciclo();
    endtask

    initial begin
        int rise0, rise1, qcnt_a, qcnt_b;

        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) begin
                m_cnt[d][c] = -1; m_pulso[d][c] = 0;
                m_trava[d][c] = 1'b0; m_flag[d][c] = 1'b0;
            end

        // Reset with idle inputs.
        rst = 1'b1; infravermelho = 2'b11; enable = 2'b00; limpa_flag = 2'b00;
        #2;
        ciclo();
        chk("rst.estado", 32'(est_a), 32'h0);
        chk("rst.C",      32'(c_a),   32'h0);
        chk("rst.flag",   32'(flg_b), 32'h0);
        ciclos(4);
        rst = 1'b0;
        ciclo();

        // Timeout on channel 0.
        infravermelho = 2'b10; enable = 2'b01;
        ciclo();
        chk("entrada.contando", 32'(est_a[1:0]), 32'd1);
        ciclos(19);
        chk("pre_timeout.C", 32'(c_a[0]), 32'd0);
        ciclo();
        chk("timeout.C",    32'(c_a[0]), 32'd1);
        chk("timeout.flag", 32'(flg_a[0]), 32'd1);
        ciclos(2);
        chk("pulso.C_ultimo", 32'(c_b[0]), 32'd1);
        ciclo();
        chk("pulso.fim_a", 32'(est_a[1:0]), 32'd0);
        chk("pulso.fim_b", 32'(est_b[1:0]), 32'd3);
        ciclo();
        chk("rearme.a", 32'(est_a[1:0]), 32'd1);

        // Release everything, then reset in the middle of a count.
        infravermelho = 2'b11; enable = 2'b00;
        ciclos(2);
        infravermelho = 2'b10; enable = 2'b01;
        ciclos(11);
        rst = 1'b1;
        ciclo();
        chk("rst_meio.estado", 32'(est_a), 32'h0);
        chk("rst_meio.flag",   32'(flg_a), 32'h0);
        rst = 1'b0;
        infravermelho = 2'b11; enable = 2'b00;
        ciclo();

        // Abort exactly at the last counting cycle.
        infravermelho = 2'b10; enable = 2'b01;
        ciclo();
        ciclos(19);
        enable = 2'b00;
        ciclo();
        chk("aborto.estado", 32'(est_a[1:0]), 32'd0);
        chk("aborto.C",      32'(c_a[0]), 32'd0);
        ciclos(5);
        chk("aborto.flag",   32'(flg_a[0]), 32'd0);
        infravermelho = 2'b11;
        ciclos(2);

        // Channel independence: channel 1 starts seven edges after channel 0.
        rise0 = -1; rise1 = -1; qcnt_a = 0; qcnt_b = 0;
        infravermelho = 2'b10; enable = 2'b01;
        for (int k = 0; k < 36; k++) begin
            if (k == 7) begin
                infravermelho = 2'b00; enable = 2'b11;
            end
            ciclo();
            if (c_a[0] && rise0 < 0) rise0 = k;
            if (c_a[1] && rise1 < 0) rise1 = k;
            if (q_a) qcnt_a++;
            if (q_b) qcnt_b++;
        end
        chk("indep.rise0", 32'(rise0), 32'd20);
        chk("indep.diff",  32'(rise1 - rise0), 32'd7);
        chk("indep.qc_a",  32'(qcnt_a), 32'd6);
        chk("indep.qc_b",  32'(qcnt_b), 32'd6);

        // Latch mode holds while presence persists.
        ciclos(50);
        chk("trava.estado", 32'(est_b), 32'hF);
        chk("trava.C",      32'(c_b),   32'h0);
        infravermelho = 2'b11;
        ciclo();
        chk("trava.solta", 32'(est_b), 32'h0);

        // Flag clear coinciding with, then following, TEMP entry.
        limpa_flag = 2'b11; enable = 2'b00;
        ciclo();
        limpa_flag = 2'b00;
        infravermelho = 2'b10; enable = 2'b01;
        ciclos(20);
        limpa_flag = 2'b01;
        ciclo();
        chk("limpa.simultaneo", 32'(flg_a[0]), 32'd1);
        ciclo();
        chk("limpa.depois", 32'(flg_a[0]), 32'd0);
        limpa_flag = 2'b00;
        infravermelho = 2'b11; enable = 2'b00;
        ciclos(4);

        // Randomised traffic: presence mostly held, rare resets.
        infravermelho = 2'b00; enable = 2'b11;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 29) == 0) infravermelho[c] = ~infravermelho[c];
                if ($urandom_range(0, 49) == 0) enable[c] = ~enable[c];
                limpa_flag[c] = ($urandom_range(0, 15) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            ciclo();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/temporizador_multicanal.md
# temporizador_multicanal

- Parametrised, multi-channel successor to the single-channel presence timer in the controller datapath.
- Each channel watches its own active-low infrared input, qualified by an enable, and counts while presence persists.
- On timeout a channel drives its `C` output high for a configurable number of cycles, then either re-arms immediately or latches until the sensor clears.
- Sits between the debounce stage and the mode/shutdown logic of `controladora`; exposes per-channel state and sticky timeout flags for status readout.

## Interface

- `N_CANAIS`, default 4: number of independent channels, ≥1.
- `TIMEOUT`, default 30000: cycles a channel must spend in CONTANDO before timing out, ≥2.
- `PULSO_T`, default 1: cycles `C` stays high per timeout, ≥1.
- `TRAVA`, default 0: 0 returns to INICIAL after the pulse; 1 holds in ESPERA until `infravermelho` returns to 1.
- `CNT_W`, default `$clog2(TIMEOUT)`: counter width, derived, not overridden.

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `enable`  in  N_CANAIS  per-channel count enable.
- `infravermelho`  in  N_CANAIS  per-channel sensor, 0 = presence.
- `limpa_flag`  in  N_CANAIS  per-channel one-cycle clear of `flag_evento`.
- `C`  out  N_CANAIS  per-channel timeout pulse.
- `qualquer_c`  out  1  OR of all `C` bits.
- `estado`  out  2*N_CANAIS  per-channel state code, channel i at bits [2i+1:2i].
- `flag_evento`  out  N_CANAIS  sticky "timeout occurred" per channel.

## Operation

- Each channel has an identical, independent FSM plus a `CNT_W`-bit counter `Tc`. There is no cross-channel interaction except `qualquer_c`.
- State codes: INICIAL=0, CONTANDO=1, TEMP=2, ESPERA=3.
- INICIAL:
  - `Tc`=0.
  - Go to CONTANDO when `infravermelho`=0 and `enable`=1. Otherwise stay.
- CONTANDO:
  - If `infravermelho`=1 or `enable`=0, go to INICIAL and set `Tc`=0. Abort takes priority over timeout in the same cycle.
  - Else if `Tc`=TIMEOUT-1, go to TEMP and set `Tc`=0.
  - Else `Tc`+1.
- TEMP:
  - `C`=1 and inputs are ignored.
  - `Tc` counts pulse cycles. When `Tc`=PULSO_T-1:
    - TRAVA=0: go to INICIAL.
    - TRAVA=1: go to ESPERA.
    - In both cases set `Tc`=0.
- ESPERA (only reachable with TRAVA=1):
  - `C`=0.
  - Go to INICIAL when `infravermelho`=1. `enable` is ignored.
- Outputs:
  - `C[i]` is decoded (Moore) from the state register (state==TEMP). It is glitch-free and not delayed further.
  - `qualquer_c` is the combinational OR of `C`.
  - `flag_evento[i]` is set on the edge entering TEMP and cleared by `limpa_flag[i]`. If set and clear occur in the same cycle, set wins.
- Counter never wraps; its maximum reached value is max(TIMEOUT, PULSO_T)-1.

## Timing

- Reset:
  - All states INICIAL, `Tc`=0, `flag_evento`=0.
  - Hence `C`=0, `qualquer_c`=0, `estado`=0 on the first edge with `rst`=1.
  - `rst` mid-count or mid-pulse aborts immediately. No pulse completion, no flag set.
- Entry latency: condition sampled true at edge k gives state CONTANDO after edge k.
- Timeout latency: with conditions held, state TEMP (`C`=1) after edge k+TIMEOUT.
- Pulse width: `C` is high for exactly PULSO_T cycles.
- Re-arm, TRAVA=0:
  - With the condition still true, the channel re-enters CONTANDO one edge after leaving TEMP.
  - Period between rising edges of `C` is PULSO_T+1+TIMEOUT cycles.
- Abort: a condition drop sampled at edge m while in CONTANDO gives INICIAL after edge m. An abort at `Tc`=TIMEOUT-1 produces no pulse.
- Simultaneous timeouts on several channels each pulse independently; `qualquer_c` is high while any pulse is high.

## Test plan

Parameters for all scenarios: N_CANAIS=2, TIMEOUT=20, PULSO_T=3.

- Reset: hold `rst` for 5 cycles with inputs idle (`infravermelho`=2'b11) -> `estado`=0, `C`=0, `flag_evento`=0; repeat the reset mid-CONTANDO (`Tc`=10) -> all outputs back to reset values on the next edge.
- Timeout, channel 0 (TRAVA=0): drive `infravermelho[0]`=0, `enable[0]`=1 at edge k -> CONTANDO after k, `C[0]`=1 after k+20 for exactly 3 cycles, `flag_evento[0]`=1, then re-enter CONTANDO.
- Abort at boundary: drop `enable[0]` when `Tc`=19 -> INICIAL, `C[0]` never rises, `flag_evento[0]` stays 0.
- Independence: start channel 1 seven cycles after channel 0 -> `C[1]` rises 7 cycles after `C[0]`; `qualquer_c` is high for 3+3 cycles across the two pulses (non-overlapping).
- Latch mode (TRAVA=1): after the pulse, hold `infravermelho`=0 for 50 cycles -> state ESPERA (3), `C`=0, no re-count; raise `infravermelho` -> INICIAL on the next edge.
- Flag clear: pulse `limpa_flag[0]` on the same edge as TEMP entry -> `flag_evento[0]`=1; pulse it one cycle later -> `flag_evento[0]`=0.
